// File: rtl/mshr_ctrl.sv
// mshr_ctrl: two-entry miss status holding register with merge and a single-outstanding memory FSM
module mshr_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_adr,
  output logic              miss_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_adr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_dat,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_adr,
  output logic [DATA_W-1:0] fill_dat,
  output logic              full,
  output logic              busy,
  output logic [7:0]        merge_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
  state_t            state;
  logic [1:0]        valid, issued, hit, cand;
  logic [ADDR_W-1:0] adr [2];
  logic              old, cur, sel, a, fill_hit, accept, alloc, other_alive;
  always_comb begin
    hit[0]      = valid[0] && adr[0] == miss_adr && !(state == FILL && !cur);
    hit[1]      = valid[1] && adr[1] == miss_adr && !(state == FILL && cur);
    fill_hit    = state == FILL && adr[cur] == miss_adr;
    full        = &valid;
    busy        = |valid || state != IDLE;
    miss_ready  = (|hit || !full) && !fill_hit;
    accept      = miss_valid && miss_ready;
    alloc       = accept && !(|hit);
    a           = valid[0];
    cand        = valid & ~issued;
    sel         = &cand ? old : cand[1];
    other_alive = valid[!a] && !(state == FILL && cur == !a);
  end
  // old indexes the older entry; a fresh allocation is always the youngest
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      valid         <= '0;
      issued        <= '0;
      adr[0]        <= '0;
      adr[1]        <= '0;
      old           <= 1'b0;
      cur           <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_adr   <= '0;
      fill_valid    <= 1'b0;
      fill_adr      <= '0;
      fill_dat      <= '0;
      merge_cnt     <= '0;
    end else begin
      if (accept && |hit && merge_cnt != 8'hff) merge_cnt <= merge_cnt + 8'd1;
      if (alloc) begin
        valid[a]  <= 1'b1;
        issued[a] <= 1'b0;
        adr[a]    <= miss_adr;
      end
      case (state)
        IDLE: if (|cand) begin
          issued[sel] <= 1'b1;
          cur         <= sel;
          mem_req_adr <= adr[sel];
          state       <= REQ;
        end
        REQ: if (!mem_req_valid) mem_req_valid <= 1'b1;
          else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        WAIT: if (mem_resp_valid) begin
          fill_valid <= 1'b1;
          fill_adr   <= adr[cur];
          fill_dat   <= mem_resp_dat;
          state      <= FILL;
        end
        FILL: begin
          fill_valid <= 1'b0;
          valid[cur] <= 1'b0;
          old        <= !cur;
          state      <= IDLE;
        end
      endcase
      if (alloc) old <= other_alive ? !a : a;
    end
  end
endmodule

// File: tb/tb_mshr_ctrl.sv
// tb_mshr_ctrl: directed scoreboard bench for mshr_ctrl
module tb_mshr_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        miss_valid = 1'b0, miss_ready;
  logic [31:0] miss_adr = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_adr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_dat = '0;
  logic        fill_valid, full, busy;
  logic [31:0] fill_adr, fill_dat;
  logic [7:0]  merge_cnt;
  int          errors = 0, checks = 0;
  logic [31:0] req_q [$];
  logic [63:0] fill_q [$];

  mshr_ctrl dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_adr(miss_adr), .miss_ready(miss_ready),
    .mem_req_valid(mem_req_valid), .mem_req_adr(mem_req_adr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_dat(mem_resp_dat), .fill_valid(fill_valid),
    .fill_adr(fill_adr), .fill_dat(fill_dat), .full(full), .busy(busy), .merge_cnt(merge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An empty queue yields X, so an unexpected handshake or fill can never match
  always @(negedge clk) begin
    logic [31:0] er;
    logic [63:0] ef;
    if (rst && mem_req_valid && mem_req_ready) begin
      er = req_q.size() != 0 ? req_q.pop_front() : 'x;
      check("req_handshake", mem_req_adr, er);
    end
    if (fill_valid) begin
      ef = fill_q.size() != 0 ? fill_q.pop_front() : 'x;
      check("fill_data", {fill_adr, fill_dat}, ef);
    end
  end

  task automatic miss(input logic [31:0] adr, input bit alloc);
    int n = 0;
    miss_valid = 1'b1;
    miss_adr   = adr;
    #1;
    while (!miss_ready && n < 20) begin tick(); n++; end
    check("miss_accept", miss_ready, 1);
    if (alloc) req_q.push_back(adr);
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req_valid && n < 30) begin tick(); n++; end
    check("req_valid", mem_req_valid, 1);
  endtask

  task automatic serve(input logic [31:0] adr, input logic [31:0] dat, input int dly,
                       input bit blk, input logic [31:0] fm);
    wait_req();
    check("req_adr", mem_req_adr, adr);
    if (blk) check("miss_blocked_req", miss_ready, 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (dly) tick();
    mem_resp_valid = 1'b1;
    mem_resp_dat   = dat;
    fill_q.push_back({adr, dat});
    tick();
    mem_resp_valid = 1'b0;
    check("fill_pulse", fill_valid, 1);
    if (blk) check("miss_blocked_fill", miss_ready, 0);
    if (fm != 0) begin
      miss_valid = 1'b1;
      miss_adr   = fm;
      #1;
      check("alloc_in_fill", miss_ready, 1);
      req_q.push_back(fm);
    end
    tick();
    if (fm != 0) miss_valid = 1'b0;
    check("fill_one_cycle", fill_valid, 0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_fill_valid", fill_valid, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_merge_cnt", merge_cnt, 0);
    check("rst_req_adr", mem_req_adr, 0);
    check("rst_fill_adr", fill_adr, 0);
    check("rst_fill_dat", fill_dat, 0);
    rst = 1'b1;
    tick();
    check("rst_miss_ready", miss_ready, 1);

    // single miss with request latency of two edges after acceptance
    miss(32'h100, 1);
    check("lat_k", mem_req_valid, 0);
    check("busy_after_miss", busy, 1);
    tick();
    check("lat_k1", mem_req_valid, 0);
    tick();
    check("lat_k2", mem_req_valid, 1);
    serve(32'h100, 32'hDEADBEEF, 3, 0, 0);
    check("idle_after_fill", busy, 0);

    // merge then a second address
    miss(32'h200, 1);
    miss(32'h200, 0);
    miss(32'h300, 1);
    check("merge_cnt_one", merge_cnt, 1);
    serve(32'h200, 32'h2222_0000, 1, 0, 0);
    check("no_req_right_after_fill", mem_req_valid, 0);
    serve(32'h300, 32'h3333_0000, 2, 0, 0);
    check("merge_busy_done", busy, 0);

    // full: third miss waits for the first fill
    miss(32'h10, 1);
    miss(32'h20, 1);
    check("full_set", full, 1);
    miss_valid = 1'b1;
    miss_adr   = 32'h30;
    #1;
    check("full_blocks", miss_ready, 0);
    req_q.push_back(32'h30);
    serve(32'h10, 32'h0000_0010, 1, 1, 0);
    check("ready_after_free", miss_ready, 1);
    tick();
    miss_valid = 1'b0;
    check("full_again", full, 1);
    serve(32'h20, 32'h0000_0020, 0, 0, 0);
    serve(32'h30, 32'h0000_0030, 0, 0, 0);

    // allocation in the same cycle as a fill
    miss(32'h40, 1);
    serve(32'h40, 32'h4444_4444, 0, 0, 32'h50);
    check("alloc_fill_busy", busy, 1);
    check("alloc_fill_full", full, 0);
    serve(32'h50, 32'h5555_5555, 1, 0, 0);

    // backpressure
    miss(32'h400, 1);
    wait_req();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", mem_req_valid, 1);
      check("bp_adr", mem_req_adr, 32'h400);
      tick();
    end
    serve(32'h400, 32'h0400_0400, 2, 0, 0);

    // reset while waiting for a response
    miss(32'h500, 1);
    wait_req();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_req_valid", mem_req_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_merge_cnt", merge_cnt, 0);
    check("mid_rst_fill_valid", fill_valid, 0);
    tick();
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_dat   = 32'hBAD0_BAD0;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    check("late_resp_no_fill", fill_valid, 0);
    check("late_resp_idle", busy, 0);

    // merge counter saturation
    miss_valid = 1'b1;
    miss_adr   = 32'h600;
    req_q.push_back(32'h600);
    repeat (301) tick();
    miss_valid = 1'b0;
    check("merge_saturate", merge_cnt, 255);
    serve(32'h600, 32'h0600_0600, 1, 0, 0);
    check("sat_busy_done", busy, 0);

    repeat (3) tick();
    check("req_q_drained", req_q.size(), 0);
    check("fill_q_drained", fill_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mshr_ctrl.md
MSHR_CTRL -- requirements
Module: mshr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, miss/request address width.
REQ-002 SHALL have parameter DATA_W, default 32, fill data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port miss_valid  input  1  cache presents a read miss.
REQ-006 SHALL have port miss_adr  input  ADDR_W  miss line address.
REQ-007 SHALL have port miss_ready  output  1  miss accepted when miss_valid and miss_ready are both high at a rising edge.
REQ-008 SHALL have port mem_req_valid  output  1  memory read request.
REQ-009 SHALL have port mem_req_adr  output  ADDR_W  request address.
REQ-010 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-011 SHALL have port mem_resp_valid  input  1  memory returns data; no backpressure.
REQ-012 SHALL have port mem_resp_dat  input  DATA_W  returned data.
REQ-013 SHALL have port fill_valid  output  1  one-cycle fill pulse to cache.
REQ-014 SHALL have port fill_adr  output  ADDR_W  fill address.
REQ-015 SHALL have port fill_dat  output  DATA_W  fill data.
REQ-016 SHALL have port full  output  1  both entries valid.
REQ-017 SHALL have port busy  output  1  any entry valid or FSM not IDLE.
REQ-018 SHALL have port merge_cnt  output  8  saturating count of merged misses.

Function
REQ-019 SHALL hold 2 entries, each: valid, issued, adr, plus 1 age bit marking the older entry.
REQ-020 SHALL merge a miss whose miss_adr equals a valid entry not in FILL: accept, no allocation, merge_cnt +1, saturating at 255.
REQ-021 SHALL otherwise allocate the lowest free index on acceptance, with issued=0 and the new entry marked youngest.
REQ-022 SHALL drive miss_ready = merge hit OR !full; deassert it when miss_adr equals the entry currently in FILL.
REQ-023 SHALL compute full from registered valid bits; an entry freed in FILL is reusable only from the next cycle.
REQ-024 SHALL run memory FSM states IDLE, REQ, WAIT, FILL.
REQ-025 SHALL, in IDLE, with any valid unissued entry, select the oldest, go to REQ next edge, and mark it issued.
REQ-026 SHALL, in REQ, hold mem_req_valid=1 and mem_req_adr stable until mem_req_ready, then go to WAIT.
REQ-027 SHALL, in WAIT, capture mem_resp_dat on mem_resp_valid, then go to FILL.
REQ-028 SHALL, in FILL, assert fill_valid for exactly 1 cycle with the entry adr and captured data, clear the entry valid bit, and return to IDLE.
REQ-029 SHALL ignore mem_resp_valid outside WAIT.
REQ-030 SHALL keep only one memory request outstanding.
REQ-031 SHALL latency: miss accepted at edge k with FSM IDLE -> mem_req_valid high after edge k+2.
REQ-032 SHALL latency: mem_resp_valid sampled at edge j -> fill_valid high after edge j.
REQ-033 SHALL, for a simultaneous allocate and fill, apply both; a simultaneous merge and fill to different addresses keeps both entries correct.

Reset
REQ-034 SHALL, on rst low, asynchronously clear all entries, age, and merge_cnt, and force FSM to IDLE.
REQ-035 SHALL reset outputs: mem_req_valid=0, fill_valid=0, full=0, busy=0, merge_cnt=0, mem_req_adr/fill_adr/fill_dat=0; miss_ready=1 once rst is high.
REQ-036 SHALL, on reset mid-transaction, drop in-flight requests and ignore any late response.

Verification
REQ-037 SHALL cover single miss: adr 0x100 accepted, mem_req_ready=1, response 0xDEADBEEF after 3 cycles -> one fill_valid pulse with adr 0x100 and data 0xDEADBEEF; busy=0 afterwards.
REQ-038 SHALL cover merge: 0x200 twice, then 0x300 -> one request for 0x200, merge_cnt=1, then a request for 0x300 only after 0x200 fills.
REQ-039 SHALL cover full: misses 0x10 and 0x20, third miss 0x30 -> miss_ready=0 until the cycle after the 0x10 fill, then 0x30 is accepted.
REQ-040 SHALL cover backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and adr held stable; exactly one handshake.
REQ-041 SHALL cover reset in WAIT: rst low -> outputs at reset values in the same cycle; a later mem_resp_valid produces no fill.
REQ-042 SHALL cover saturation: 300 merged misses -> merge_cnt=255.
